arithmetic_logic_unit: RTL

Integer execution unit that responds to the reservation station's issue interface. It accepts one ready instruction per cycle (op, immediate, PC, both operand values, destination ROB tag) and computes the RV32I result in one registered stage. It drives the result onto its common-data-bus slot for the reservation station, load/store buffer and reorder buffer. For control-flow ops it also resolves the branch outcome and target for the reorder buffer.

---
 rtl/arithmetic_logic_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/arithmetic_logic_unit.sv
// RV32I integer execution unit: one registered stage from RS issue to CDB slot.
// Also resolves jump/branch outcome and target for the reorder buffer.
`ifndef ALU_HEADER_DEFS
`define ALU_HEADER_DEFS
`define WORD_RANGE 31:0
`define INNER_INST_RANGE 5:0
`define ROB_TAG_RANGE 4:0
`define NULL_TAG 5'd0
`define OP_NOP 6'd0
`define OP_LUI 6'd1
`define OP_AUIPC 6'd2
`define OP_JAL 6'd3
`define OP_JALR 6'd4
`define OP_BEQ 6'd5
`define OP_BNE 6'd6
`define OP_BLT 6'd7
`define OP_BGE 6'd8
`define OP_BLTU 6'd9
`define OP_BGEU 6'd10
`define OP_ADDI 6'd19
`define OP_SLTI 6'd20
`define OP_SLTIU 6'd21
`define OP_XORI 6'd22
`define OP_ORI 6'd23
`define OP_ANDI 6'd24
`define OP_SLLI 6'd25
`define OP_SRLI 6'd26
`define OP_SRAI 6'd27
`define OP_ADD 6'd28
`define OP_SUB 6'd29
`define OP_SLL 6'd30
`define OP_SLT 6'd31
`define OP_SLTU 6'd32
`define OP_XOR 6'd33
`define OP_SRL 6'd34
`define OP_SRA 6'd35
`define OP_OR 6'd36
`define OP_AND 6'd37
`endif

module arithmetic_logic_unit (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rob_rollback_in,
  input  logic                      rs_calculate_signal_in,
  input  logic [`INNER_INST_RANGE]  rs_op_in,
  input  logic [`WORD_RANGE]        rs_imm_in,
  input  logic [`WORD_RANGE]        rs_pc_in,
  input  logic [`WORD_RANGE]        rs_rs1val_in,
  input  logic [`WORD_RANGE]        rs_rs2val_in,
  input  logic [`ROB_TAG_RANGE]     rs_dest_in,
  output logic                      broadcast_signal_out,
  output logic [`WORD_RANGE]        result_out,
  output logic [`ROB_TAG_RANGE]     dest_tag_out,
  output logic                      jump_flag_out,
  output logic [`WORD_RANGE]        target_pc_out
);

  logic                  bcast_d, bcast_q;
  logic [`WORD_RANGE]    result_d, result_q;
  logic [`ROB_TAG_RANGE] tag_d, tag_q;
  logic                  jump_d, jump_q;
  logic [`WORD_RANGE]    target_d, target_q;

  logic [`WORD_RANGE] a, b, pc4, pc_imm;
  logic [`WORD_RANGE] alu_res, alu_tgt;
  logic [4:0]         shamt;
  logic               alu_jmp;
  logic               is_imm;

  // I-type ops take the immediate in place of rs2
  always_comb begin
    is_imm = 1'b0;
    case (rs_op_in)
      `OP_ADDI, `OP_SLTI, `OP_SLTIU,
      `OP_XORI, `OP_ORI, `OP_ANDI,
      `OP_SLLI, `OP_SRLI, `OP_SRAI:
        is_imm = 1'b1;
      default: is_imm = 1'b0;
    endcase
  end

  assign a      = rs_rs1val_in;
  assign b      = is_imm ? rs_imm_in : rs_rs2val_in;
  assign shamt  = b[4:0];
  assign pc4    = rs_pc_in + 32'd4;
  assign pc_imm = rs_pc_in + rs_imm_in;

  always_comb begin
    alu_res = '0;
    alu_jmp = 1'b0;
    alu_tgt = pc4;
    case (rs_op_in)
      `OP_LUI:   alu_res = rs_imm_in;
      `OP_AUIPC: alu_res = pc_imm;
      `OP_JAL: begin
        alu_res = pc4;
        alu_jmp = 1'b1;
        alu_tgt = pc_imm;
      end
      `OP_JALR: begin
        alu_res = pc4;
        alu_jmp = 1'b1;
        alu_tgt = (a + rs_imm_in) & ~32'd1;
      end
      `OP_BEQ:  alu_jmp = (a == b);
      `OP_BNE:  alu_jmp = (a != b);
      `OP_BLT:  alu_jmp = ($signed(a) < $signed(b));
      `OP_BGE:  alu_jmp = ($signed(a) >= $signed(b));
      `OP_BLTU: alu_jmp = (a < b);
      `OP_BGEU: alu_jmp = (a >= b);
      `OP_ADD, `OP_ADDI: alu_res = a + b;
      `OP_SUB:  alu_res = a - b;
      `OP_SLT, `OP_SLTI:
        alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      `OP_SLTU, `OP_SLTIU:
        alu_res = (a < b) ? 32'd1 : 32'd0;
      `OP_XOR, `OP_XORI: alu_res = a ^ b;
      `OP_OR, `OP_ORI:   alu_res = a | b;
      `OP_AND, `OP_ANDI: alu_res = a & b;
      `OP_SLL, `OP_SLLI: alu_res = a << shamt;
      `OP_SRL, `OP_SRLI: alu_res = a >> shamt;
      `OP_SRA, `OP_SRAI:
        alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
    // Taken branches redirect; not-taken ones fall through to pc+4
    if (alu_jmp && rs_op_in != `OP_JAL && rs_op_in != `OP_JALR)
      alu_tgt = pc_imm;
  end

  always_comb begin
    bcast_d  = 1'b0;
    result_d = result_q;
    tag_d    = tag_q;
    jump_d   = jump_q;
    target_d = target_q;
    if (rst || rob_rollback_in) begin
      result_d = '0;
      tag_d    = `NULL_TAG;
      jump_d   = 1'b0;
      target_d = '0;
    end else if (rs_calculate_signal_in) begin
      bcast_d  = 1'b1;
      result_d = alu_res;
      tag_d    = rs_dest_in;
      jump_d   = alu_jmp;
      target_d = alu_tgt;
    end
  end

  always_ff @(posedge clk) begin
    bcast_q  <= bcast_d;
    result_q <= result_d;
    tag_q    <= tag_d;
    jump_q   <= jump_d;
    target_q <= target_d;
  end

  assign broadcast_signal_out = bcast_q;
  assign result_out           = result_q;
  assign dest_tag_out         = tag_q;
  assign jump_flag_out        = jump_q;
  assign target_pc_out        = target_q;

endmodule
